// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, RAM port-B and output stream signals of the burst reader
interface ram_stream_reader_if #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic [ADDR_SIZE-1:0] cmd_len;
    logic [ADDR_SIZE-1:0] ram_addr_b;
    logic                 ram_r_e_b;
    logic [DATA_SIZE-1:0] ram_data_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_last;
    logic                 done;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, ram_data_b, out_ready,
        output cmd_ready, ram_addr_b, ram_r_e_b, out_valid, out_data, out_last, done
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, ram_data_b, out_ready,
        input  cmd_ready, ram_addr_b, ram_r_e_b, out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader for RAM port B delivering words on a valid/ready stream
module ram_stream_reader #(
    parameter int ADDR_SIZE  = 16,
    parameter int DATA_SIZE  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nrst,
    ram_stream_reader_if.slave bus
);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 3);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        occ;
    logic [CW-1:0]        lim;
    logic                 pend;
    logic                 valid;
    logic                 pop;
    logic                 issue;
    logic [ADDR_SIZE-1:0] words_left;
    logic [ADDR_SIZE-1:0] remaining;

    // Occupancy counts the FIFO plus both reads whose data is not yet captured
    // (the one issued now and the one whose data is on the bus); a pop this
    // cycle frees a slot early, which keeps a depth of 3 at one word per cycle.
    always_comb begin
        valid         = count != '0;
        pop           = valid && bus.out_ready;
        bus.out_valid = valid;
        bus.out_data  = valid ? mem[rd_ptr] : '0;
        bus.out_last  = valid && remaining == ADDR_SIZE'(1);
        occ           = count + CW'(bus.ram_r_e_b) + CW'(pend);
        lim           = CW'(FIFO_DEPTH) + CW'(pop);
        issue         = words_left != '0 && occ < lim;
    end

    // FIFO storage: capture RAM data the cycle after each issued read.
    always_ff @(posedge clk) begin
        if (pend) mem[wr_ptr] <= bus.ram_data_b;
    end

    // FIFO pointers and occupancy; reset flushes everything in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pend   <= 1'b0;
        end else begin
            pend  <= bus.ram_r_e_b;
            count <= count + CW'(pend) - CW'(pop);
            if (pend) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
        end
    end

    // Burst control: accept a command, issue reads under FIFO credit, drain, pulse done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            bus.cmd_ready  <= 1'b1;
            bus.ram_r_e_b  <= 1'b0;
            bus.ram_addr_b <= '0;
            bus.done       <= 1'b0;
            words_left     <= '0;
            remaining      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        remaining     <= bus.cmd_len;
                        if (bus.cmd_len != '0) begin
                            state          <= READ;
                            bus.ram_r_e_b  <= 1'b1;
                            bus.ram_addr_b <= bus.cmd_addr;
                            words_left     <= bus.cmd_len - ADDR_SIZE'(1);
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (words_left == '0) begin
                        state         <= DRAIN;
                        bus.ram_r_e_b <= 1'b0;
                    end else if (issue) begin
                        bus.ram_r_e_b  <= 1'b1;
                        bus.ram_addr_b <= bus.ram_addr_b + ADDR_SIZE'(1);
                        words_left     <= words_left - ADDR_SIZE'(1);
                    end else begin
                        bus.ram_r_e_b <= 1'b0;
                    end
                    if (pop) remaining <= remaining - ADDR_SIZE'(1);
                end
                DRAIN: begin
                    if (pop) begin
                        remaining <= remaining - ADDR_SIZE'(1);
                        if (remaining == ADDR_SIZE'(1)) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.done      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench for the RAM burst reader
module tb_ram_stream_reader;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

    ram_stream_reader #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cnt = 0, hs_cyc = 0, done_cnt = 0, done_cyc = 0;
    int pop_cnt = 0, ov_cnt = 0, re_cnt = 0;
    int first_re = -1, first_out = -1, last_out = -1;
    int p_pop = 0, p_ov = 0, p_re = 0;
    logic [AW-1:0] addr_q[$];
    logic [DW:0]   exp_q[$];
    logic          hold = 1'b0;
    logic          prev_done = 1'b0;
    logic [DW:0]   held = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [DW-1:0] ram_word(logic [AW-1:0] a);
        return {16'h0, a} * 32'd3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM port B model: one-cycle synchronous read, RAM[i] = i*3.
    always @(posedge clk) if (bus.ram_r_e_b) bus.ram_data_b <= ram_word(bus.ram_addr_b);

    // Monitor: pops expectations whenever the DUT issues a read or delivers a word.
    always @(negedge clk) begin
        if (!nrst) begin
            hold = 1'b0;
            prev_done = 1'b0;
            re_cnt = pop_cnt;
        end else begin
            if (prev_done) chk("ready_after_done", bus.cmd_ready, 1);
            if (hold) chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, held});
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs_cnt++;
                hs_cyc = cyc;
            end
            if (bus.ram_r_e_b) begin
                re_cnt++;
                if (first_re < 0) first_re = cyc;
                if (addr_q.size() == 0) chk("extra_read", 1, 0);
                else chk("ram_addr", bus.ram_addr_b, addr_q.pop_front());
                chk("outstanding_le_depth", (re_cnt - pop_cnt) <= FD, 1);
            end
            if (bus.out_valid) ov_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else chk("out_word", {bus.out_last, bus.out_data}, exp_q.pop_front());
            end
            hold = bus.out_valid && !bus.out_ready;
            held = {bus.out_last, bus.out_data};
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("ready_low_in_done", bus.cmd_ready, 0);
            end
            prev_done = bus.done;
        end
    end

    task automatic mark();
        p_pop = pop_cnt;
        p_ov = ov_cnt;
        p_re = re_cnt;
        first_re = -1;
        first_out = -1;
        last_out = -1;
    endtask

    task automatic expect_burst(input logic [AW-1:0] a, input logic [AW-1:0] n);
        for (int i = 0; i < int'(n); i++) begin
            addr_q.push_back(a + AW'(i));
            exp_q.push_back({i == int'(n) - 1, ram_word(a + AW'(i))});
        end
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] n);
        int s = hs_cnt;
        expect_burst(a, n);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = a;
        bus.cmd_len = n;
        for (int i = 0; i < 50 && hs_cnt == s; i++) begin
            @(posedge clk);
            #1;
        end
        chk("cmd_accept", hs_cnt != s, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input bit bp);
        int s = done_cnt;
        int i = 0;
        while (done_cnt == s && i < 400) begin
            bus.out_ready = bp ? (i % 3 == 0) : 1'b1;
            @(posedge clk);
            #1;
            i++;
        end
        bus.out_ready = 1'b1;
        chk("done_seen_once", done_cnt - s, 1);
    endtask

    initial begin
        int s, d0, r0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_r_e", bus.ram_r_e_b, 0);
        chk("rst_addr", bus.ram_addr_b, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_done", bus.done, 0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        mark();
        send(16'h0010, 16'd4);
        wait_done(1'b0);
        chk("basic_first_read", first_re, hs_cyc + 1);
        chk("basic_first_word", first_out, hs_cyc + 3);
        chk("basic_last_word", last_out, hs_cyc + 6);
        chk("basic_done", done_cyc, hs_cyc + 7);
        chk("basic_words", pop_cnt - p_pop, 4);

        mark();
        send(16'h0100, 16'd8);
        wait_done(1'b1);
        chk("bp_words", pop_cnt - p_pop, 8);
        chk("bp_reads", re_cnt - p_re, 8);
        chk("bp_slowed", done_cyc - hs_cyc >= 24, 1);

        mark();
        send(16'hFFFE, 16'd4);
        wait_done(1'b0);
        chk("wrap_words", pop_cnt - p_pop, 4);

        mark();
        send(16'h0500, 16'd0);
        wait_done(1'b0);
        chk("len0_done", done_cyc, hs_cyc + 1);
        chk("len0_no_valid", ov_cnt - p_ov, 0);
        chk("len0_no_read", re_cnt - p_re, 0);

        mark();
        s = hs_cnt;
        d0 = done_cnt;
        expect_burst(16'h0020, 16'd3);
        expect_burst(16'h0040, 16'd2);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr = 16'h0020;
        bus.cmd_len = 16'd3;
        for (int i = 0; i < 50 && hs_cnt == s; i++) begin
            @(posedge clk);
            #1;
        end
        bus.cmd_addr = 16'h0040;
        bus.cmd_len = 16'd2;
        for (int i = 0; i < 100 && hs_cnt < s + 2; i++) begin
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        chk("busy_two_accepts", hs_cnt - s, 2);
        chk("busy_first_done", done_cnt - d0, 1);
        chk("busy_accept_cycle", hs_cyc, done_cyc + 1);
        wait_done(1'b0);
        chk("busy_words", pop_cnt - p_pop, 5);

        mark();
        send(16'h0200, 16'd16);
        for (int i = 0; i < 100 && pop_cnt - p_pop < 5; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        nrst = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_r_e", bus.ram_r_e_b, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_done", bus.done, 0);
        chk("abort_out_data", bus.out_data, 0);
        addr_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        r0 = re_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        chk("abort_no_read", re_cnt, r0);
        mark();
        send(16'h0300, 16'd2);
        wait_done(1'b0);
        chk("post_abort_words", pop_cnt - p_pop, 2);

        chk("addr_q_empty", addr_q.size(), 0);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
